sin_gen: RTL and testbench
==========================

SIN_GEN -- requirements
Module: sin_gen

Interface
REQ-001 SHALL have parameter PHASE_STEP, default 7'd1, the phase increment per clock (1..127).
REQ-002 SHALL have port clk, input, 1, the only clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1, reset; synchronous to clk and active-high.
REQ-004 SHALL have port out_val, output, 8, signed two's-complement sine sample, registered.

Function
REQ-005 SHALL hold a 7-bit phase register p, covering 128 phase points per period.
REQ-006 SHALL, on every clk rising edge with rst low, load out_val <= S(p) and p <= (p + PHASE_STEP) mod 128.
- Result: at the k-th post-reset edge (k>=1), out_val = S(((k-1)*PHASE_STEP) mod 128).
REQ-007 SHALL define S(p) = round-half-away-from-zero(127*sin(2*pi*p/128)).
- Range is -127..+127; -128 SHALL never appear.
REQ-008 SHALL derive S from a 33-entry quarter table Q[k] = S(k), k=0..32, using symmetry:
- p in 0..32 -> Q[p]
- p in 33..64 -> Q[64-p]
- p in 65..96 -> -Q[p-64]
- p in 97..127 -> -Q[128-p]
REQ-009 SHALL wrap the phase silently from 127 to 0 with no glitch or extra cycle; period = 128/gcd(128,PHASE_STEP) clocks.
REQ-010 SHALL have latency exactly one clock from phase value to out_val, with no combinational path from any input to out_val.
REQ-011 SHALL produce the following anchor values: S(0)=0, S(8)=49, S(16)=90, S(32)=127, S(48)=90, S(64)=0, S(96)=-127, S(112)=-90.

Reset
REQ-012 SHALL, on a clk rising edge with rst high, set p=0 and out_val=0; rst SHALL take priority over the update.
REQ-013 SHALL, on rst asserted mid-period, restart the sequence from phase 0 on the first edge after release.
REQ-014 SHALL leave out_val undefined before the first reset edge; benches SHALL apply reset before checking values.

Configuration
REQ-015 SHALL support macro SIN_GEN_QUARTER_WAVE_EN:
- Defined: lookup uses the 33-entry quarter table plus the symmetry logic of REQ-008.
- Undefined: lookup uses a direct 128-entry full-period table holding S(p).
- Both builds SHALL be cycle- and bit-identical on out_val.

Structure
REQ-016 SHALL place in shared package sin_gen_pkg:
- PHASE_W=7 and OUT_W=8
- the sample typedef (signed 8-bit)
- the phase typedef (unsigned 7-bit)
- the quarter-table constant
REQ-017 SHALL implement the phase-to-sample mapping as a combinational sub-module sin_gen_lut (phase in, sample out).
- The sin_gen top SHALL contain only the phase register and the output register.

Verification
REQ-018 SHALL cover reset: rst high for 2 edges -> out_val=0; after release, edges 1..4 give 0, 6, 12, 19.
REQ-019 SHALL cover the full period with PHASE_STEP=1, over 200 clocks after reset:
- every out_val matches S(p);
- edge 33 gives 127 and edge 97 gives -127;
- edge 129 gives 0, i.e. the wrap repeats exactly.
REQ-020 SHALL cover the output range: the minimum over a period is -127 and the maximum is +127, and -128 never appears.
REQ-021 SHALL cover PHASE_STEP=16 -> the sequence 0, 90, 127, 90, 0, -90, -127, -90, repeating with period 8.
REQ-022 SHALL cover mid-period reset: rst pulsed for one edge at post-reset edge 50 -> out_val=0 on that edge, then 0, 6, ... restarting from phase 0.
REQ-023 SHALL cover configuration equivalence: builds with and without SIN_GEN_QUARTER_WAVE_EN are compared over 256 clocks -> identical out_val traces.

Source files
------------

// File: rtl/sin_gen_pkg.sv
// Shared types and constants for the sin_gen sine generator.
// Sample values are round-half-away-from-zero(127*sin(2*pi*p/128)).
package sin_gen_pkg;

    localparam int PHASE_W = 7;
    localparam int OUT_W   = 8;

    typedef logic signed [OUT_W-1:0] sample_t;
    typedef logic [PHASE_W-1:0]      phase_t;

    // First quarter period, phase 0..32 inclusive; the other quarters are
    // obtained by mirroring and negating these entries.
    localparam sample_t QUARTER_TBL [0:32] = '{
        8'sd0,   8'sd6,   8'sd12,  8'sd19,  8'sd25,  8'sd31,  8'sd37,  8'sd43,
        8'sd49,  8'sd54,  8'sd60,  8'sd65,  8'sd71,  8'sd76,  8'sd81,  8'sd85,
        8'sd90,  8'sd94,  8'sd98,  8'sd102, 8'sd106, 8'sd109, 8'sd112, 8'sd115,
        8'sd117, 8'sd120, 8'sd122, 8'sd123, 8'sd125, 8'sd126, 8'sd126, 8'sd127,
        8'sd127
    };

endpackage

// File: rtl/sin_gen_lut.sv
// Combinational phase-to-sample mapping for sin_gen.
// Define SIN_GEN_QUARTER_WAVE_EN to fold the phase onto the quarter table;
// otherwise a full 128-entry period table is used. Both give identical samples.
module sin_gen_lut
    import sin_gen_pkg::*;
(
    input  logic [PHASE_W-1:0] phase_i,
    output logic [OUT_W-1:0]   sample_o
);

`ifdef SIN_GEN_QUARTER_WAVE_EN

    logic [5:0] idx;
    logic       neg;
    sample_t    mag;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        idx = '0;
        neg = 1'b0;
        if (phase_i <= 7'd32) begin
            idx = 6'(phase_i);
        end else if (phase_i <= 7'd64) begin
            idx = 6'(7'd64 - phase_i);
        end else if (phase_i <= 7'd96) begin
            idx = 6'(phase_i - 7'd64);
            neg = 1'b1;
        end else begin
            // 128 - p, computed modulo 128 in the 7-bit phase width
            idx = 6'(7'd0 - phase_i);
            neg = 1'b1;
        end
    end

    assign mag      = QUARTER_TBL[idx];
    assign sample_o = neg ? -mag : mag;

`else

    localparam sample_t FULL_TBL [0:127] = '{
        8'sd0,    8'sd6,    8'sd12,   8'sd19,   8'sd25,   8'sd31,   8'sd37,   8'sd43,
        8'sd49,   8'sd54,   8'sd60,   8'sd65,   8'sd71,   8'sd76,   8'sd81,   8'sd85,
        8'sd90,   8'sd94,   8'sd98,   8'sd102,  8'sd106,  8'sd109,  8'sd112,  8'sd115,
        8'sd117,  8'sd120,  8'sd122,  8'sd123,  8'sd125,  8'sd126,  8'sd126,  8'sd127,
        8'sd127,  8'sd127,  8'sd126,  8'sd126,  8'sd125,  8'sd123,  8'sd122,  8'sd120,
        8'sd117,  8'sd115,  8'sd112,  8'sd109,  8'sd106,  8'sd102,  8'sd98,   8'sd94,
        8'sd90,   8'sd85,   8'sd81,   8'sd76,   8'sd71,   8'sd65,   8'sd60,   8'sd54,
        8'sd49,   8'sd43,   8'sd37,   8'sd31,   8'sd25,   8'sd19,   8'sd12,   8'sd6,
        8'sd0,   -8'sd6,   -8'sd12,  -8'sd19,  -8'sd25,  -8'sd31,  -8'sd37,  -8'sd43,
       -8'sd49,  -8'sd54,  -8'sd60,  -8'sd65,  -8'sd71,  -8'sd76,  -8'sd81,  -8'sd85,
       -8'sd90,  -8'sd94,  -8'sd98,  -8'sd102, -8'sd106, -8'sd109, -8'sd112, -8'sd115,
       -8'sd117, -8'sd120, -8'sd122, -8'sd123, -8'sd125, -8'sd126, -8'sd126, -8'sd127,
       -8'sd127, -8'sd127, -8'sd126, -8'sd126, -8'sd125, -8'sd123, -8'sd122, -8'sd120,
       -8'sd117, -8'sd115, -8'sd112, -8'sd109, -8'sd106, -8'sd102, -8'sd98,  -8'sd94,
       -8'sd90,  -8'sd85,  -8'sd81,  -8'sd76,  -8'sd71,  -8'sd65,  -8'sd60,  -8'sd54,
       -8'sd49,  -8'sd43,  -8'sd37,  -8'sd31,  -8'sd25,  -8'sd19,  -8'sd12,  -8'sd6
    };

    assign sample_o = FULL_TBL[phase_i];

`endif

endmodule

// File: rtl/sin_gen.sv
// Sine generator: a free-running phase accumulator feeding a registered
// lookup. Output lags the phase register by exactly one clock.
module sin_gen
    import sin_gen_pkg::*;
#(
    parameter logic [PHASE_W-1:0] PHASE_STEP = 7'd1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] out_val
);

    phase_t              phase_q;
    phase_t              phase_d;
    logic [OUT_W-1:0]    out_q;
    logic [OUT_W-1:0]    lut_sample;

    // Natural 7-bit overflow gives the mod-128 wrap with no extra cycle.
    assign phase_d = phase_q + PHASE_STEP;

    sin_gen_lut u_lut (
        .phase_i  (phase_q),
        .sample_o (lut_sample)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, keeping out_q aligned to the old phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            out_q   <= '0;
        end else begin
            phase_q <= phase_d;
            out_q   <= lut_sample;
        end
    end

    assign out_val = out_q;

endmodule

// File: tb/tb_sin_gen.sv
// Directed self-checking bench for sin_gen: one instance at PHASE_STEP=1 and
// one at PHASE_STEP=16, driven from a shared clock and reset.
module tb_sin_gen;

    logic       clk;
    logic       rst;
    logic [7:0] out1;
    logic [7:0] out16;

    int checks = 0;
    int errors = 0;

    // Hand-computed round(127*sin(2*pi*k/128)), k = 0..32
    int q_ref [0:32] = '{
        0, 6, 12, 19, 25, 31, 37, 43, 49, 54, 60, 65, 71, 76, 81, 85,
        90, 94, 98, 102, 106, 109, 112, 115, 117, 120, 122, 123, 125, 126, 126, 127,
        127
    };

    int seq16 [0:7] = '{0, 90, 127, 90, 0, -90, -127, -90};

    sin_gen #(.PHASE_STEP(7'd1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .out_val (out1)
    );

    sin_gen #(.PHASE_STEP(7'd16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .out_val (out16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int s_ref(input int p);
        int m;
        int mag;
        m   = p % 64;
        mag = (m <= 32) ? q_ref[m] : q_ref[64 - m];
        return (p >= 64) ? -mag : mag;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s1;
        int s16;
        int vmin;
        int vmax;
        int seen_m128;

        rst = 1'b1;
        tick();
        tick();
        check("reset_out1", int'($signed(out1)), 0);
        check("reset_out16", int'($signed(out16)), 0);

        rst       = 1'b0;
        vmin      = 1000;
        vmax      = -1000;
        seen_m128 = 0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            s1  = int'($signed(out1));
            s16 = int'($signed(out16));
            check($sformatf("step1_edge%0d", k), s1, s_ref((k - 1) % 128));
            check($sformatf("step16_edge%0d", k), s16, seq16[(k - 1) % 8]);
            if (out1 == 8'h80 || out16 == 8'h80) seen_m128 = 1;
            if (k <= 128) begin
                if (s1 < vmin) vmin = s1;
                if (s1 > vmax) vmax = s1;
            end
            case (k)
                1:   check("edge1_zero", s1, 0);
                2:   check("edge2_six", s1, 6);
                3:   check("edge3_twelve", s1, 12);
                4:   check("edge4_nineteen", s1, 19);
                9:   check("anchor_s8", s1, 49);
                17:  check("anchor_s16", s1, 90);
                33:  check("anchor_s32_peak", s1, 127);
                49:  check("anchor_s48", s1, 90);
                65:  check("anchor_s64_zero", s1, 0);
                97:  check("anchor_s96_trough", s1, -127);
                113: check("anchor_s112", s1, -90);
                129: check("wrap_edge129", s1, 0);
                130: check("wrap_edge130", s1, 6);
                default: ;
            endcase
        end
        check("range_min", vmin, -127);
        check("range_max", vmax, 127);
        check("no_minus128", seen_m128, 0);

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 49; k++) begin
            tick();
        end
        check("pre_midreset_edge49", int'($signed(out1)), 90);
        rst = 1'b1;
        tick();
        check("midreset_edge50_out1", int'($signed(out1)), 0);
        check("midreset_edge50_out16", int'($signed(out16)), 0);
        rst = 1'b0;
        tick();
        check("restart_edge1", int'($signed(out1)), 0);
        check("restart16_edge1", int'($signed(out16)), 0);
        tick();
        check("restart_edge2", int'($signed(out1)), 6);
        check("restart16_edge2", int'($signed(out16)), 90);
        tick();
        check("restart_edge3", int'($signed(out1)), 12);
        tick();
        check("restart_edge4", int'($signed(out1)), 19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
